// File: rtl/shift_seq_pkg.sv
// Purpose: shared constants, op encodings and FSM states for the sequential shift unit.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package shift_seq_pkg;

  localparam int XLEN = 32;
  localparam int SHW  = 5;

  localparam logic [1:0] OP_SLL  = 2'b00;
  localparam logic [1:0] OP_SRL  = 2'b01;
  localparam logic [1:0] OP_PASS = 2'b10;
  localparam logic [1:0] OP_SRA  = 2'b11;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

endpackage

// File: rtl/shift_seq_unit_dec.sv
// Purpose: binary shift amount to one-hot code, in the format the one-hot shifter consumes.
// Latency: combinational, zero cycles.
// Backpressure: none; pure function of its input.
// Ports: shamt_i = binary shift amount, onehot_o = bit shamt_i set, all others clear.
module shamt_onehot_dec #(
  parameter int XLEN = 32,
  parameter int SHW  = 5
) (
  input  logic [SHW-1:0]  shamt_i,
  output logic [XLEN-1:0] onehot_o
);

  assign onehot_o = {{(XLEN-1){1'b0}}, 1'b1} << shamt_i;

endmodule

// File: rtl/shift_seq_unit.sv
// Purpose: 32-bit SLL/SRL/SRA as a 5-stage log shifter, one stage per clock, plus one-hot shamt.
// Latency: fixed; out_valid rises in the 5th cycle after the accept cycle, for any shamt.
// Backpressure: result held in DONE until out_ready; a new request may be accepted in the handoff cycle.
// Ports: clk/rst_n (async active-low); in_valid/in_ready/in_op/in_shamt/in_data request side;
//        flush kills in-flight work; out_valid/out_ready/out_data/out_onehot result side.
module shift_seq_unit #(
  parameter int XLEN = shift_seq_pkg::XLEN,
  parameter int SHW  = shift_seq_pkg::SHW
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [1:0]      in_op,
  input  logic [SHW-1:0]  in_shamt,
  input  logic [XLEN-1:0] in_data,
  input  logic            flush,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_data,
  output logic [XLEN-1:0] out_onehot
);

  import shift_seq_pkg::*;

  state_t          state_q;
  logic [1:0]      op_q;
  logic [SHW-1:0]  shamt_q;
  logic [XLEN-1:0] work_q;
  logic            sign_q;
  logic [2:0]      k_q;
  logic            out_valid_q;
  logic [XLEN-1:0] out_data_q;
  logic [XLEN-1:0] out_onehot_q;

  logic            accept;
  logic [XLEN-1:0] in_onehot;
  logic [XLEN-1:0] stage_d;
  logic [XLEN-1:0] fill_mask;
  int unsigned     amt;

  shamt_onehot_dec #(
    .XLEN (XLEN),
    .SHW  (SHW)
  ) u_dec (
    .shamt_i  (in_shamt),
    .onehot_o (in_onehot)
  );

  // rst_n gates in_ready directly so the request side looks busy for the whole reset.
  assign in_ready = rst_n & ~flush &
                    ((state_q == IDLE) | ((state_q == DONE) & out_ready));
  assign accept   = in_valid & in_ready;

  // One log-shifter stage: shift by 2^k when bit k of the captured shamt is set.
  // SRA fills from the sign bit latched at accept, not from the working register.
  always_comb begin
    amt       = 32'd1 << k_q;
    fill_mask = sign_q ? ~({XLEN{1'b1}} >> amt) : '0;
    stage_d   = work_q;
    if (shamt_q[k_q]) begin
      case (op_q)
        OP_SLL:  stage_d = work_q << amt;
        OP_SRL:  stage_d = work_q >> amt;
        OP_SRA:  stage_d = (work_q >> amt) | fill_mask;
        default: stage_d = work_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      op_q         <= '0;
      shamt_q      <= '0;
      work_q       <= '0;
      sign_q       <= 1'b0;
      k_q          <= '0;
      out_valid_q  <= 1'b0;
      out_data_q   <= '0;
      out_onehot_q <= '0;
    end else if (flush) begin
      state_q     <= IDLE;
      out_valid_q <= 1'b0;
      k_q         <= '0;
    end else if (accept) begin
      // Reached from IDLE, or from DONE during the handoff cycle.
      state_q      <= SHIFT;
      op_q         <= in_op;
      shamt_q      <= in_shamt;
      work_q       <= in_data;
      sign_q       <= in_data[XLEN-1];
      k_q          <= '0;
      out_valid_q  <= 1'b0;
      out_onehot_q <= in_onehot;
    end else begin
      case (state_q)
        SHIFT: begin
          work_q <= stage_d;
          k_q    <= k_q + 3'd1;
          if (k_q == 3'(SHW-1)) begin
            state_q     <= DONE;
            out_valid_q <= 1'b1;
            out_data_q  <= stage_d;
          end
        end
        DONE: begin
          if (out_ready) begin
            state_q     <= IDLE;
            out_valid_q <= 1'b0;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign out_valid  = out_valid_q;
  assign out_data   = out_data_q;
  assign out_onehot = out_onehot_q;

endmodule

// File: tb/tb_shift_seq_unit.sv
// Purpose: self-checking bench for shift_seq_unit: arithmetic reference model plus directed literals.
// Latency: expects out_valid in the 5th cycle after each accept.
// Backpressure: exercises held results, same-cycle handoff/accept, flush and async reset.
module tb_shift_seq_unit;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [1:0]  in_op = 2'b00;
  logic [4:0]  in_shamt = 5'd0;
  logic [31:0] in_data = 32'd0;
  logic        flush = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] out_data;
  logic [31:0] out_onehot;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  shift_seq_unit dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_op      (in_op),
    .in_shamt   (in_shamt),
    .in_data    (in_data),
    .flush      (flush),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .out_onehot (out_onehot)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] golden(input logic [1:0] op, input logic [31:0] d,
                                         input logic [4:0] s);
    logic [31:0] r;
    case (op)
      2'b00:   r = d << s;
      2'b01:   r = d >> s;
      2'b11:   r = $signed(d) >>> s;
      default: r = d;
    endcase
    return r;
  endfunction

  // Reference model: a request is "in flight" for a counted number of cycles,
  // then its precomputed result is presented until taken.
  int          m_cnt;
  logic        m_valid;
  logic [31:0] m_res;
  logic [31:0] m_data;
  logic [31:0] m_oh;
  logic        m_ready;

  assign m_ready = rst_n && !flush &&
                   ((m_cnt < 0 && !m_valid) || (m_valid && out_ready));

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_cnt   <= -1;
      m_valid <= 1'b0;
      m_res   <= 32'd0;
      m_data  <= 32'd0;
      m_oh    <= 32'd0;
    end else if (flush) begin
      m_cnt   <= -1;
      m_valid <= 1'b0;
    end else if (in_valid && m_ready) begin
      m_cnt   <= 1;
      m_valid <= 1'b0;
      m_res   <= golden(in_op, in_data, in_shamt);
      m_oh    <= 32'd1 << in_shamt;
    end else if (m_valid && out_ready) begin
      m_valid <= 1'b0;
    end else if (m_cnt == 5) begin
      m_cnt   <= -1;
      m_valid <= 1'b1;
      m_data  <= m_res;
    end else if (m_cnt >= 1) begin
      m_cnt <= m_cnt + 1;
    end
  end

  always @(negedge clk) begin
    check("in_ready", {31'd0, in_ready}, {31'd0, m_ready});
    check("out_valid", {31'd0, out_valid}, {31'd0, m_valid});
    if (m_valid) begin
      check("out_data", out_data, m_data);
      check("out_onehot", out_onehot, m_oh);
    end
  end

  // Presents a request at posedge+1 and holds it until accepted; returns at the accept edge +1.
  task automatic send(input logic [1:0] op, input logic [31:0] d, input logic [4:0] s);
    logic ok;
    bit   done;
    done     = 0;
    in_op    = op;
    in_data  = d;
    in_shamt = s;
    in_valid = 1'b1;
    for (int i = 0; i < 20; i++) begin
      #1;
      ok = in_ready;
      @(posedge clk);
      #1;
      if (ok) begin
        done = 1;
        break;
      end
    end
    in_valid = 1'b0;
    if (!done) begin
      errors++;
      $display("FAIL send_timeout actual=no_accept required=accept");
    end
  endtask

  task automatic wait_valid(output int n);
    n = 0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk);
      #1;
      n++;
      if (out_valid) break;
    end
  endtask

  task automatic wait_result(input string name, input logic [31:0] exp_d, input logic [31:0] exp_oh);
    int n;
    wait_valid(n);
    check({name, "_latency"}, n, 32'd5);
    check({name, "_data"}, out_data, exp_d);
    check({name, "_onehot"}, out_onehot, exp_oh);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
  endtask

  task automatic run(input string name, input logic [1:0] op, input logic [31:0] d,
                     input logic [4:0] s, input logic [31:0] exp_d, input logic [31:0] exp_oh);
    send(op, d, s);
    wait_result(name, exp_d, exp_oh);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    #1 rst_n = 1'b0;
    #2;
    check("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("rst_out_data", out_data, 32'd0);
    check("rst_out_onehot", out_onehot, 32'd0);
    check("rst_in_ready", {31'd0, in_ready}, 32'd0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    #1;
    check("release_in_ready", {31'd0, in_ready}, 32'd1);

    run("sll31",     2'b00, 32'h0000_0001, 5'd31, 32'h8000_0000, 32'h8000_0000);
    run("srl4",      2'b01, 32'h8000_0000, 5'd4,  32'h0800_0000, 32'h0000_0010);
    run("sra4_neg",  2'b11, 32'h8000_0000, 5'd4,  32'hF800_0000, 32'h0000_0010);
    run("sra4_pos",  2'b11, 32'h7FFF_FFF0, 5'd4,  32'h07FF_FFFF, 32'h0000_0010);
    run("sll0",      2'b00, 32'hA5A5_1234, 5'd0,  32'hA5A5_1234, 32'h0000_0001);
    run("srl0",      2'b01, 32'h8000_0001, 5'd0,  32'h8000_0001, 32'h0000_0001);
    run("sra0",      2'b11, 32'h8000_0001, 5'd0,  32'h8000_0001, 32'h0000_0001);
    run("sra13",     2'b11, 32'h9000_0000, 5'd13, 32'hFFFC_8000, 32'h0000_2000);

    // Backpressure: result held for three cycles, then same-cycle handoff and accept.
    send(2'b11, 32'hF0F0_0000, 5'd12);
    wait_valid(n);
    check("bp_latency", n, 32'd5);
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      check("bp_hold_valid", {31'd0, out_valid}, 32'd1);
      check("bp_hold_data", out_data, 32'hFFFF_0F00);
      check("bp_hold_onehot", out_onehot, 32'h0000_1000);
      check("bp_hold_in_ready", {31'd0, in_ready}, 32'd0);
    end
    in_op     = 2'b00;
    in_data   = 32'h0000_0001;
    in_shamt  = 5'd8;
    in_valid  = 1'b1;
    out_ready = 1'b1;
    #1;
    check("b2b_in_ready", {31'd0, in_ready}, 32'd1);
    @(posedge clk);
    #1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    wait_result("b2b", 32'h0000_0100, 32'h0000_0100);

    // Flush while stage 2 is pending; the request must vanish.
    send(2'b01, 32'hFFFF_FFFF, 5'd1);
    repeat (2) begin
      @(posedge clk);
      #1;
    end
    flush = 1'b1;
    #1;
    check("flush_in_ready", {31'd0, in_ready}, 32'd0);
    @(posedge clk);
    #1;
    // A request offered during a flush cycle in IDLE is not taken.
    in_op    = 2'b00;
    in_data  = 32'h0000_00FF;
    in_shamt = 5'd3;
    in_valid = 1'b1;
    #1;
    check("flush_idle_in_ready", {31'd0, in_ready}, 32'd0);
    @(posedge clk);
    #1;
    flush    = 1'b0;
    in_valid = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk);
      #1;
      check("flush_no_valid", {31'd0, out_valid}, 32'd0);
    end
    run("after_flush", 2'b00, 32'h1234_5678, 5'd4, 32'h2345_6780, 32'h0000_0010);

    // Asynchronous reset in the middle of SHIFT clears outputs with no clock edge.
    send(2'b00, 32'h0000_0003, 5'd2);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("arst_out_valid", {31'd0, out_valid}, 32'd0);
    check("arst_out_data", out_data, 32'd0);
    check("arst_out_onehot", out_onehot, 32'd0);
    check("arst_in_ready", {31'd0, in_ready}, 32'd0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    #1;
    check("rerelease_in_ready", {31'd0, in_ready}, 32'd1);
    for (int i = 0; i < 6; i++) begin
      @(posedge clk);
      #1;
      check("arst_no_valid", {31'd0, out_valid}, 32'd0);
    end
    run("pass", 2'b10, 32'hDEAD_BEEF, 5'd7, 32'hDEAD_BEEF, 32'h0000_0080);

    repeat (3) @(posedge clk);
    #1;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
